afifo_wr_arbiter: RTL and testbench
===================================

Name: afifo_wr_arbiter

Overview:
- Write-side controller for the async FIFO: shares the single FIFO write port (wr_data/wr_inc/wr_full) between NREQ requesters in the wr_clk domain.
- Round-robin arbitration with packet locking: once a requester starts a multi-beat packet, it owns the port until its last beat or a MAX_BURST forced release.
- Sits between producer blocks and the FIFO write interface.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DSIZE, 8, data width; must match the FIFO's DSIZE.
- MAX_BURST, 4, max beats per grant before forced release (>=1).

Ports:
- wr_clk  in  1  write-domain clock
- wr_rst  in  1  reset; synchronous, active-low
- req_valid  in  NREQ  per-requester beat valid
- req_last  in  NREQ  per-requester last beat of packet
- req_data  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE]
- req_ready  out  NREQ  one-hot beat accept
- wr_full  in  1  FIFO full flag
- wr_inc  out  1  FIFO write strobe
- wr_data  out  DSIZE  FIFO write data
- grant_id  out  $clog2(NREQ)  current selected/owner index
- busy  out  1  high while a packet lock is held
- stat_beats  out  NREQ*16  accepted-beat counters (optional feature)
- stat_forced  out  16  forced-release count (optional feature)

Behaviour:
- Reset (wr_rst==0 sampled at posedge wr_clk): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, stats=0. While wr_rst==0, outputs are forced: wr_inc=0, req_ready=0, wr_data=0, grant_id=0, busy=0. Reset mid-packet drops the lock with no further handshake.
- Beat = req_valid[g] && req_ready[g]. Zero latency: wr_inc, wr_data, req_ready are combinational from the current state and inputs. The FIFO captures on the same wr_clk edge.
- wr_full==1: req_ready=0, wr_inc=0; state, rr_ptr, beat_cnt frozen.
- IDLE:
  - pick = first i with req_valid[i], scanning circularly from rr_ptr.
  - If none valid: grant_id=rr_ptr, wr_inc=0.
  - If a valid requester exists and !wr_full: beat from pick; wr_inc=1, wr_data=req_data[pick].
  - If req_last[pick] or MAX_BURST==1: stay IDLE, rr_ptr <= (pick+1) mod NREQ.
  - Otherwise: go to LOCKED, owner<=pick, beat_cnt<=1.
- LOCKED:
  - Only the owner is served; grant_id=owner, busy=1.
  - Owner beat: beat_cnt++.
  - If req_last[owner] or beat_cnt+1==MAX_BURST: go to IDLE, rr_ptr <= (owner+1) mod NREQ, beat_cnt<=0.
  - Owner not valid: stall in LOCKED; other requesters are not served.
- Simultaneous requests: strictly rotating priority. No starvation: any valid requester is served within NREQ grants.
- req_ready is at most one-hot. wr_inc == |req_ready.

Optional Feature:
- Macro AFIFO_ARB_STATS_EN.
- Defined:
  - stat_beats[i] increments on each beat from requester i, saturating at 16'hFFFF.
  - stat_forced increments on each MAX_BURST release taken without req_last, saturating.
  - All counters clear on reset.
- Undefined: the ports still exist and are tied to 0; no counter flops are built.

Decomposition:
- Shared package afifo_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}
  - STAT_W=16
  - function rr_next(ptr, nreq)
- Sub-module afifo_rr_pick: combinational circular first-one finder over req_valid from rr_ptr. Outputs pick index and any_valid.
- Top holds the FSM, pointer, counters and muxes.

Test Plan (NREQ=4, DSIZE=8, MAX_BURST=4):
- Reset: hold wr_rst=0 for 3 cycles with all req_valid=1 -> wr_inc=0, req_ready=0, busy=0. After release, first grant goes to requester 0.
- Round-robin: all valid, all last=1, data i=8'hA0+i, 8 cycles -> wr_data sequence A0,A1,A2,A3,A0,A1,A2,A3, one beat per cycle.
- Packet lock: req1 sends 3 beats with last on the 3rd, req0/req2 valid throughout -> beats 1,1,1, then requester 2 is granted. busy=1 during beats 2-3.
- Forced release: req3 sends 6 beats with last=0 -> 4 beats accepted, then IDLE and requester 0 granted. stat_forced=1 when AFIFO_ARB_STATS_EN is defined.
- Full backpressure: wr_full=1 for 5 cycles mid-packet -> no wr_inc, beat_cnt and owner unchanged. Packet resumes unchanged after wr_full drops.
- Owner stall: owner deasserts valid for 2 cycles in LOCKED while others are valid -> no beats accepted, lock held, owner resumes.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
package afifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

  function automatic int rr_next(input int ptr, input int nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester / FIFO-write bundle; slave = arbiter side, master = producers + FIFO side.
interface afifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  import afifo_arb_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_last;
  logic [NREQ*DSIZE-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wr_full;
  logic                   wr_inc;
  logic [DSIZE-1:0]       wr_data;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic [NREQ*STAT_W-1:0] stat_beats;
  logic [STAT_W-1:0]      stat_forced;

  modport slave (
    input  req_valid, req_last, req_data, wr_full,
    output req_ready, wr_inc, wr_data, grant_id, busy, stat_beats, stat_forced
  );

  modport master (
    output req_valid, req_last, req_data, wr_full,
    input  req_ready, wr_inc, wr_data, grant_id, busy, stat_beats, stat_forced
  );

endinterface

// File: rtl/afifo_rr_pick.sv
// Circular first-one finder: lowest set bit of i_valid at or after i_ptr, wrapping.
module afifo_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_pick,
  output logic            o_any
);

  always_comb begin
    int w_idx;
    w_idx  = 0;
    o_pick = i_ptr;
    o_any  = |i_valid;
    // Scan from farthest offset down so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (i_valid[IDW'(w_idx)]) o_pick = IDW'(w_idx);
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter for one async-FIFO write port; zero-latency beats,
// wr_full freezes everything. Counters built only with AFIFO_ARB_STATS_EN defined.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input logic               wr_clk,
  input logic               wr_rst,
  afifo_wr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  arb_state_t     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_owner;
  logic [CW-1:0]  r_beat_cnt;

  logic [IDW-1:0] w_pick;
  logic           w_any;
  logic [IDW-1:0] w_sel;
  logic           w_sel_vld;
  logic           w_last;
  logic           w_burst_end;
  logic           w_beat;
  logic           w_release;

  afifo_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  assign w_sel       = (r_state == LOCKED) ? r_owner : w_pick;
  assign w_sel_vld   = (r_state == LOCKED) ? bus.req_valid[r_owner] : w_any;
  assign w_last      = bus.req_last[w_sel];
  assign w_burst_end = (r_state == LOCKED) ? (int'(r_beat_cnt) + 1 == MAX_BURST)
                                           : (MAX_BURST == 1);
  assign w_beat      = wr_rst && !bus.wr_full && w_sel_vld;
  assign w_release   = w_beat && (w_last || w_burst_end);

  assign bus.wr_inc    = w_beat;
  assign bus.req_ready = w_beat ? (NREQ'(1) << w_sel) : '0;
  assign bus.wr_data   = wr_rst ? bus.req_data[w_sel*DSIZE +: DSIZE] : '0;
  assign bus.busy      = wr_rst && (r_state == LOCKED);
  assign bus.grant_id  = !wr_rst              ? '0      :
                         (r_state == LOCKED)  ? r_owner :
                         w_any                ? w_pick  : r_rr_ptr;

  always_ff @(posedge wr_clk) begin
    if (!wr_rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      if (w_release) begin
        r_state    <= IDLE;
        r_rr_ptr   <= IDW'(rr_next(int'(w_sel), NREQ));
        r_beat_cnt <= '0;
      end else if (r_state == IDLE) begin
        r_state    <= LOCKED;
        r_owner    <= w_pick;
        r_beat_cnt <= CW'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end

`ifdef AFIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_beats [NREQ];
  logic [STAT_W-1:0] r_stat_forced;
  logic              w_forced;

  // A forced release is one ended by the burst limit rather than by req_last.
  assign w_forced = w_beat && !w_last && w_burst_end;

  always_ff @(posedge wr_clk) begin
    if (!wr_rst) begin
      for (int i = 0; i < NREQ; i++) r_stat_beats[i] <= '0;
      r_stat_forced <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_beat && (w_sel == IDW'(i)) && (r_stat_beats[i] != '1))
          r_stat_beats[i] <= r_stat_beats[i] + 1'b1;
      end
      if (w_forced && (r_stat_forced != '1))
        r_stat_forced <= r_stat_forced + 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign bus.stat_beats[g*STAT_W +: STAT_W] = r_stat_beats[g];
  end
  assign bus.stat_forced = r_stat_forced;
`else
  assign bus.stat_beats  = '0;
  assign bus.stat_forced = '0;
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed scoreboard bench for afifo_wr_arbiter (NREQ=4, DSIZE=8, MAX_BURST=4).
module tb_afifo_wr_arbiter;

`ifdef AFIFO_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] rdy;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b0;

  afifo_wr_arbiter_if #(.NREQ(4), .DSIZE(8)) bus ();

  afifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(4)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       sb [$];
  logic [8:0] pq [4][$];
  logic [3:0] hold = '0;
  logic [3:0] acc  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (pq[i].size() != 0) begin
        bus.req_valid[i]       = !hold[i];
        bus.req_last[i]        = pq[i][0][8];
        bus.req_data[i*8 +: 8] = pq[i][0][7:0];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_last[i]        = 1'b0;
        bus.req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    refresh();
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic last);
    pq[id].push_back({last, d});
    refresh();
  endtask

  task automatic expect_beat(input int id, input logic [7:0] d);
    exp_t e;
    e.rdy  = 4'(1 << id);
    e.id   = 2'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  function automatic bit pending();
    bit p;
    p = (sb.size() != 0);
    for (int i = 0; i < 4; i++) if (pq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    for (int k = 0; k < 60 && pending(); k++) step();
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares every accepted beat against the scoreboard head.
  always @(negedge wr_clk) begin
    exp_t e;
    acc = bus.req_ready;
    if (wr_rst) begin
      check("inc_eq_or_ready", 32'(bus.wr_inc), 32'(|bus.req_ready));
      if (bus.wr_inc) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got id %0d data %0h expected none at %0t",
                   bus.grant_id, bus.wr_data, $time);
        end else begin
          e = sb.pop_front();
          check("beat", 32'({bus.req_ready, bus.grant_id, bus.wr_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_full   = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;

    // Reset with all requesters valid; then round-robin over single-beat packets.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        load(i, 8'(8'hA0 + i), 1'b1);
        expect_beat(i, 8'(8'hA0 + i));
      end
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_wr_inc",   32'(bus.wr_inc),    32'd0);
      check("rst_ready",    32'(bus.req_ready), 32'd0);
      check("rst_busy",     32'(bus.busy),      32'd0);
      check("rst_wr_data",  32'(bus.wr_data),   32'd0);
    end
    wr_rst = 1'b1;
    #1;
    check("first_grant", 32'(bus.grant_id), 32'd0);
    for (int c = 0; c < 8; c++) step();
    check("rr_one_per_cycle", 32'(sb.size()), 32'd0);
    drain("drain_rr");

    // Move the pointer to 1, then a 3-beat packet from req1 with req0/req2 waiting.
    load(0, 8'h0F, 1'b1);
    expect_beat(0, 8'h0F);
    drain("drain_pre");
    load(0, 8'h10, 1'b1);
    load(1, 8'h11, 1'b0);
    load(1, 8'h12, 1'b0);
    load(1, 8'h13, 1'b1);
    load(2, 8'h20, 1'b1);
    expect_beat(1, 8'h11);
    expect_beat(1, 8'h12);
    expect_beat(1, 8'h13);
    expect_beat(2, 8'h20);
    expect_beat(0, 8'h10);
    step();
    check("lock_busy_b2",  32'(bus.busy),     32'd1);
    check("lock_grant_b2", 32'(bus.grant_id), 32'd1);
    step();
    check("lock_busy_b3",  32'(bus.busy),     32'd1);
    step();
    check("unlock_busy",   32'(bus.busy),     32'd0);
    check("after_lock_grant", 32'(bus.grant_id), 32'd2);
    drain("drain_lock");

    // Forced release: req3 streams without last, req0 waits.
    for (int i = 0; i < 6; i++) load(3, 8'(8'h30 + i), (i == 5));
    load(0, 8'h40, 1'b1);
    for (int i = 0; i < 4; i++) expect_beat(3, 8'(8'h30 + i));
    expect_beat(0, 8'h40);
    expect_beat(3, 8'h34);
    expect_beat(3, 8'h35);
    for (int c = 0; c < 4; c++) step();
    check("forced_busy",  32'(bus.busy),     32'd0);
    check("forced_grant", 32'(bus.grant_id), 32'd0);
    drain("drain_forced");
    check("stat_forced_1", 32'(bus.stat_forced), STATS ? 32'd1 : 32'd0);

    // Full backpressure mid-packet; the burst count must survive the stall.
    for (int i = 0; i < 5; i++) load(2, 8'(8'h50 + i), (i == 4));
    load(3, 8'h60, 1'b1);
    for (int i = 0; i < 4; i++) expect_beat(2, 8'(8'h50 + i));
    expect_beat(3, 8'h60);
    expect_beat(2, 8'h54);
    step();
    bus.wr_full = 1'b1;
    for (int c = 0; c < 5; c++) step();
    check("full_wr_inc", 32'(bus.wr_inc),    32'd0);
    check("full_ready",  32'(bus.req_ready), 32'd0);
    check("full_busy",   32'(bus.busy),      32'd1);
    check("full_owner",  32'(bus.grant_id),  32'd2);
    bus.wr_full = 1'b0;
    drain("drain_full");

    // Owner stall: req0 drops valid inside its packet while req1 waits.
    load(0, 8'h70, 1'b0);
    load(0, 8'h71, 1'b0);
    load(0, 8'h72, 1'b1);
    load(1, 8'h80, 1'b1);
    expect_beat(0, 8'h70);
    expect_beat(0, 8'h71);
    expect_beat(0, 8'h72);
    expect_beat(1, 8'h80);
    step();
    hold[0] = 1'b1;
    refresh();
    for (int c = 0; c < 2; c++) step();
    check("stall_busy",   32'(bus.busy),     32'd1);
    check("stall_owner",  32'(bus.grant_id), 32'd0);
    check("stall_wr_inc", 32'(bus.wr_inc),   32'd0);
    hold[0] = 1'b0;
    refresh();
    drain("drain_stall");

    check("stat_beats_0", 32'(bus.stat_beats[0  +: 16]), STATS ? 32'd8 : 32'd0);
    check("stat_beats_1", 32'(bus.stat_beats[16 +: 16]), STATS ? 32'd6 : 32'd0);
    check("stat_beats_2", 32'(bus.stat_beats[32 +: 16]), STATS ? 32'd8 : 32'd0);
    check("stat_beats_3", 32'(bus.stat_beats[48 +: 16]), STATS ? 32'd9 : 32'd0);
    check("stat_forced_2", 32'(bus.stat_forced), STATS ? 32'd2 : 32'd0);

    wr_rst = 1'b0;
    step();
    check("rst_stat_beats",  32'(|bus.stat_beats), 32'd0);
    check("rst_stat_forced", 32'(bus.stat_forced), 32'd0);
    check("rst_busy_end",    32'(bus.busy),        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
